// File: rtl/mem_access_bridge.sv
// Memory-stage load/store bridge: turns M-stage load/store requests into single
// ack-handshaked word-bus transfers, stalling the pipeline until each one completes.
module mem_access_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [1:0]  memsizeM,
    input  logic        memsignedM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        addr_errM,
    output logic        bus_errM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] readdata_q, readdata_d;
    logic        bus_err_q, bus_err_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q, lane_d;
    logic        load_q, load_d;

    logic        access;
    logic        misaligned;
    logic [1:0]  lane;
    logic [3:0]  strb_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign access = memreadM | memwriteM;
    assign lane   = aluoutM[1:0];

    // Reserved size 11 behaves exactly like a word access.
    always_comb begin
        misaligned = 1'b0;
        strb_c     = 4'b1111;
        wdata_c    = writedataM;
        case (memsizeM)
            2'b00: begin
                strb_c  = 4'b0001 << lane;
                wdata_c = {4{writedataM[7:0]}};
            end
            2'b01: begin
                misaligned = lane[0];
                strb_c     = 4'b0011 << {lane[1], 1'b0};
                wdata_c    = {2{writedataM[15:0]}};
            end
            default: misaligned = (lane != 2'b00);
        endcase
    end

    // Extraction uses the size/sign/lane captured when the request was accepted.
    assign byte_sel = bus_rdata[8*lane_q +: 8];
    assign half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;
        readdata_d  = readdata_q;
        bus_err_d   = 1'b0;
        size_d      = size_q;
        signed_d    = signed_q;
        lane_d      = lane_q;
        load_d      = load_q;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = memwriteM;
                    bus_addr_d  = {aluoutM[31:2], 2'b00};
                    bus_wstrb_d = strb_c;
                    bus_wdata_d = wdata_c;
                    size_d      = memsizeM;
                    signed_d    = memsignedM;
                    lane_d      = lane;
                    load_d      = memreadM & ~memwriteM;
                    cnt_d       = 8'd0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (load_q) readdata_d = load_ext;
                    state_d   = DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    bus_req_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    readdata_d = 32'd0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wstrb_q <= 4'd0;
            bus_wdata_q <= 32'd0;
            readdata_q  <= 32'd0;
            bus_err_q   <= 1'b0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            lane_q      <= 2'd0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
            readdata_q  <= readdata_d;
            bus_err_q   <= bus_err_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            lane_q      <= lane_d;
            load_q      <= load_d;
        end
    end

    assign stallM    = access & ~misaligned & (state_q != DONE);
    assign addr_errM = access & misaligned;
    assign readdataM = readdata_q;
    assign bus_errM  = bus_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_bridge.sv
// Directed bench for mem_access_bridge (instantiated with TIMEOUT=4).
module tb_mem_access_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreadM, memwriteM, memsignedM;
    logic [1:0]  memsizeM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, addr_errM, bus_errM;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_bridge #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .memreadM(memreadM), .memwriteM(memwriteM), .memsizeM(memsizeM),
        .memsignedM(memsignedM), .aluoutM(aluoutM), .writedataM(writedataM),
        .readdataM(readdataM), .stallM(stallM), .addr_errM(addr_errM),
        .bus_errM(bus_errM), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        memreadM = 0; memwriteM = 0; memsizeM = 2'b10; memsignedM = 0;
        aluoutM = 0; writedataM = 0; bus_ack = 0; bus_rdata = 0;
    endtask

    // One complete access; ack_at = REQ cycle index carrying bus_ack, -1 for none.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rdata,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic chk_rd, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_req_cycles);
        int n;
        @(negedge clk);
        memreadM = rd; memwriteM = wr; memsizeM = sz; memsignedM = sg;
        aluoutM = addr; writedataM = wd;
        #1;
        chk({tag, ".idle_stall"}, 32'(stallM), 32'd1);
        chk({tag, ".idle_req"}, 32'(bus_req), 32'd0);
        @(negedge clk); #1;
        n = 0;
        while (bus_req === 1'b1 && n < 20) begin
            chk({tag, ".req_stall"}, 32'(stallM), 32'd1);
            if (n == 0) begin
                chk({tag, ".addr"}, bus_addr, {addr[31:2], 2'b00});
                chk({tag, ".we"}, 32'(bus_we), 32'(wr));
                chk({tag, ".wstrb"}, 32'(bus_wstrb), 32'(exp_strb));
                chk({tag, ".wdata"}, bus_wdata, exp_wdata);
            end
            if (n == ack_at) begin
                bus_ack = 1; bus_rdata = rdata;
            end
            n++;
            @(negedge clk);
            bus_ack = 0;
            #1;
        end
        chk({tag, ".req_cycles"}, 32'(n), 32'(exp_req_cycles));
        chk({tag, ".done_stall"}, 32'(stallM), 32'd0);
        chk({tag, ".done_req"}, 32'(bus_req), 32'd0);
        chk({tag, ".done_err"}, 32'(bus_errM), 32'(exp_err));
        if (chk_rd) chk({tag, ".rdata"}, readdataM, exp_rd);
        @(negedge clk);
        idle_inputs();
        #1;
        chk({tag, ".after_err"}, 32'(bus_errM), 32'd0);
        chk({tag, ".after_req"}, 32'(bus_req), 32'd0);
    endtask

    task automatic misaligned(input string tag, input logic [1:0] sz, input logic [31:0] addr);
        @(negedge clk);
        memreadM = 1; memsizeM = sz; aluoutM = addr;
        #1;
        chk({tag, ".addr_err"}, 32'(addr_errM), 32'd1);
        chk({tag, ".stall"}, 32'(stallM), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk({tag, ".no_req"}, 32'(bus_req), 32'd0);
        end
        idle_inputs();
        #1;
        chk({tag, ".clear"}, 32'(addr_errM), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #1;
        chk("rst.req", 32'(bus_req), 32'd0);
        chk("rst.we", 32'(bus_we), 32'd0);
        chk("rst.addr", bus_addr, 32'd0);
        chk("rst.wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst.wdata", bus_wdata, 32'd0);
        chk("rst.rdata", readdataM, 32'd0);
        chk("rst.err", 32'(bus_errM), 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Word store, ack in the third REQ cycle: stall for IDLE + 3 REQ cycles.
        access("wstore", 0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 2, 32'h0,
               4'b1111, 32'hDEADBEEF, 0, 32'h0, 0, 3);
        // Byte loads from lane 3.
        access("lb_s", 1, 0, 2'b00, 1, 32'h203, 32'h0, 0, 32'h80112233,
               4'b1000, 32'h0, 1, 32'hFFFFFF80, 0, 1);
        access("lb_u", 1, 0, 2'b00, 0, 32'h203, 32'h0, 0, 32'h80112233,
               4'b1000, 32'h0, 1, 32'h00000080, 0, 1);
        // Halfword store/loads and a byte store to lane 1.
        access("hstore", 0, 1, 2'b01, 0, 32'h12, 32'h0000ABCD, 0, 32'h0,
               4'b1100, 32'hABCDABCD, 0, 32'h0, 0, 1);
        access("lh_hi", 1, 0, 2'b01, 1, 32'h12, 32'h0, 0, 32'h7FFF0000,
               4'b1100, 32'h0, 1, 32'h00007FFF, 0, 1);
        access("lh_lo", 1, 0, 2'b01, 1, 32'h10, 32'h0, 1, 32'h12348765,
               4'b0011, 32'h0, 1, 32'hFFFF8765, 0, 2);
        access("bstore", 0, 1, 2'b00, 0, 32'h101, 32'h0000005A, 0, 32'h0,
               4'b0010, 32'h5A5A5A5A, 0, 32'h0, 0, 1);
        // Read+write together is a write; readdataM keeps the previous load.
        access("rw", 1, 1, 2'b10, 0, 32'h40, 32'h01020304, 0, 32'hCAFEF00D,
               4'b1111, 32'h01020304, 1, 32'hFFFF8765, 0, 1);

        misaligned("mis_w", 2'b10, 32'h102);
        misaligned("mis_h", 2'b01, 32'h101);
        misaligned("mis_r", 2'b11, 32'h103);

        // Timeout after exactly 4 REQ cycles; readdataM forced to zero.
        access("tmo", 1, 0, 2'b10, 0, 32'h80, 32'h0, -1, 32'h0,
               4'b1111, 32'h0, 1, 32'h0, 1, 4);

        // Reset in the middle of REQ.
        access("pre", 1, 0, 2'b10, 0, 32'h84, 32'h0, 0, 32'h11223344,
               4'b1111, 32'h0, 1, 32'h11223344, 0, 1);
        @(negedge clk);
        memreadM = 1; memsizeM = 2'b10; aluoutM = 32'h300;
        @(negedge clk); #1;
        chk("rstmid.req_on", 32'(bus_req), 32'd1);
        rst = 1;
        #1;
        chk("rstmid.req_off", 32'(bus_req), 32'd0);
        chk("rstmid.rdata", readdataM, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        bus_ack = 1; bus_rdata = 32'h55555555;
        @(negedge clk);
        bus_ack = 0;
        #1;
        chk("late_ack.req", 32'(bus_req), 32'd0);
        chk("late_ack.rdata", readdataM, 32'd0);
        chk("late_ack.stall", 32'(stallM), 32'd0);
        access("post", 1, 0, 2'b10, 0, 32'h300, 32'h0, 0, 32'hA5A5A5A5,
               4'b1111, 32'h0, 1, 32'hA5A5A5A5, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_bridge.md
Name: mem_access_bridge

Overview:
- Memory-stage load/store unit between the pipelined core's M-stage outputs (ALU address, store data, write enable) and a word-wide, ack-handshaked data bus.
- Generates byte/halfword/word strobes and lane-replicated write data.
- Extracts and sign- or zero-extends load data.
- Holds the pipeline with a stall while a bus transfer is outstanding, and flags misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 16, cycles to wait in REQ for bus_ack before aborting; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- memreadM  in  1  M-stage load request
- memwriteM  in  1  M-stage store request
- memsizeM  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- memsignedM  in  1  1 = sign-extend load, 0 = zero-extend
- aluoutM  in  32  byte address
- writedataM  in  32  store data, right-justified
- readdataM  out  32  extended load result; valid in DONE cycle
- stallM  out  1  freezes F/D/E/M pipeline registers
- addr_errM  out  1  misaligned access, combinational
- bus_errM  out  1  timeout abort; one-cycle pulse in DONE
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  32  {aluoutM[31:2],2'b00}, registered
- bus_wstrb  out  4  byte-lane enables, registered
- bus_wdata  out  32  lane-replicated store data, registered
- bus_ack  in  1  one-cycle transfer-complete strobe
- bus_rdata  in  32  read word; valid with bus_ack

Behaviour:
- Access = memreadM | memwriteM. If both are set, treat as a write; no read result.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - addr_errM=1 combinationally, stallM=0.
  - No bus transaction is issued and no state change occurs.
- Endianness: little-endian; lane = aluoutM[1:0].
- Strobes:
  - byte: 4'b0001<<lane
  - half: 4'b0011<<(2*lane[1])
  - word: 4'b1111
  - loads also drive these strobes.
- Write data:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Load extract: select the byte/half at lane from bus_rdata, then sign- or zero-extend to 32 bits per memsignedM.
- FSM states: IDLE, REQ, DONE. Reset → IDLE.
  - IDLE: on an aligned access, register bus_addr/we/wstrb/wdata, set bus_req=1, go to REQ. Otherwise stay in IDLE.
  - REQ: bus_req held at 1 and all bus outputs stable.
    - On bus_ack: bus_req=0, capture extended data into readdataM, go to DONE.
    - If the timeout counter reaches TIMEOUT-1 without ack: bus_req=0, set bus_errM, readdataM=0, go to DONE.
  - DONE: one cycle; go to IDLE. The pipeline advances on this edge.
- stallM = access & ~misaligned & (state≠DONE), combinational. An aligned access therefore stalls at least 2 cycles (IDLE, REQ) before the DONE cycle.
- Latency with ack in the first REQ cycle: request seen in cycle 0, ack in cycle 1, readdataM valid and stallM=0 in cycle 2.
- Timeout counter is 8-bit; cleared on entry to REQ.
- bus_errM is asserted only in the DONE cycle.
- bus_ack is ignored outside REQ.
- Inputs are stable while stalled (pipeline frozen). Changes are not sampled after IDLE.
- Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, readdataM=0, bus_errM=0, state=IDLE, counter=0.
- Reset asserted mid-REQ drops bus_req asynchronously. The transaction is abandoned; a late ack is ignored.

Test Plan:
1. Word store: memwriteM=1, size=10, addr=0x100, wd=0xDEADBEEF; ack after 3 REQ cycles. Expect bus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, we=1; stallM high for 4 cycles, then low in DONE.
2. Signed byte load: addr=0x203, bus_rdata=0x80112233, signed=1 → readdataM=0xFFFFFF80. Same access with signed=0 → 0x00000080. wstrb=1000.
3. Halfword store: addr=0x12, wd=0x0000ABCD → wstrb=1100, wdata=0xABCDABCD. Halfword load at addr=0x12, bus_rdata=0x7FFF0000, signed=1 → readdataM=0x00007FFF.
4. Misaligned: word load at 0x102 → addr_errM=1, stallM=0, bus_req never asserted. Half at 0x101 gives the same result.
5. Timeout: TIMEOUT=4, load with no ack → bus_req high exactly 4 cycles, then DONE with bus_errM=1, readdataM=0, stallM=0, then IDLE.
6. Reset mid-REQ: assert rst while bus_req=1 → bus_req=0 immediately. An ack after reset release causes no state change. The next load completes normally.
